// File: rtl/rc5_pkg.sv
// Shared RC5-32/12/16 constants, address widths and the word rotate helper.
// Used by the key expander and by anything reading its memories.
package rc5_pkg;

    localparam int W = 32;
    localparam int U = W / 8;
    localparam int B = 16;
    localparam int R = 12;
    localparam int T = 2 * (R + 1);
    localparam int C = B / U;

    localparam logic [W-1:0] PW = 32'hB7E15163;
    localparam logic [W-1:0] QW = 32'h9E3779B9;

    localparam int KAW = $clog2(B);
    localparam int TAW = $clog2(T);
    localparam int CAW = $clog2(C);
    localparam int UAW = $clog2(U);
    localparam int RW  = $clog2(W);

    localparam int MIX_ITERS = 3 * ((T > C) ? T : C);
    localparam int ITW       = $clog2(MIX_ITERS);

    typedef logic [W-1:0] word_t;

    // Left rotate: the upper half of the doubled word shifted left holds the result.
    function automatic word_t rotl(input word_t x, input logic [RW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

endpackage

// File: rtl/key_expander_if.sv
// Status bundle of the key expander; the cipher side watches done.
interface key_expander_if;
    logic done;

    modport master (output done);
    modport slave  (input  done);
endinterface

// File: rtl/rc5_ram.sv
// Generic memory: combinational read, synchronous write, no reset of contents.
module rc5_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] ram [DEPTH];

    assign rdata = ram[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/key_expander.sv
// RC5-32/12/16 key schedule: LOAD key bytes into L, INIT S from PW/QW, MIX S with L.
// done rises 198 cycles after reset release and holds; the tables then stay frozen.
module key_expander
    import rc5_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic done
);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] INIT = 2'd1;
    localparam logic [1:0] MIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [TAW-1:0] I_LAST_KEY = TAW'(B - 1);
    localparam logic [TAW-1:0] I_LAST_S   = TAW'(T - 1);
    localparam logic [CAW-1:0] J_LAST     = CAW'(C - 1);
    localparam logic [ITW-1:0] IT_LAST    = ITW'(MIX_ITERS - 1);

    logic [1:0]     state;
    logic [TAW-1:0] i;
    logic [CAW-1:0] j;
    word_t          a_reg;
    word_t          b_reg;
    logic [ITW-1:0] iter;
    logic           mix_ph;
    logic [W-9:0]   lacc;

    logic [KAW-1:0] key_addr;
    logic [7:0]     key_rdata;
    logic [CAW-1:0] l_raddr;
    logic [CAW-1:0] l_waddr;
    word_t          l_rdata;
    word_t          l_wdata;
    logic           l_we;
    logic [TAW-1:0] s_raddr;
    logic [TAW-1:0] s_waddr;
    word_t          s_rdata;
    word_t          s_wdata;
    logic           s_we;

    word_t ab_sum;
    word_t a_next;
    word_t b_next;

    assign key_addr = i[KAW-1:0];

    rc5_ram #(.DEPTH(B), .WIDTH(8)) key_RAM (
        .clk   (clk),
        .we    (1'b0),
        .waddr (key_addr),
        .wdata (8'h00),
        .raddr (key_addr),
        .rdata (key_rdata)
    );

    rc5_ram #(.DEPTH(C), .WIDTH(W)) L_RAM (
        .clk   (clk),
        .we    (l_we),
        .waddr (l_waddr),
        .wdata (l_wdata),
        .raddr (l_raddr),
        .rdata (l_rdata)
    );

    rc5_ram #(.DEPTH(T), .WIDTH(W)) S_RAM (
        .clk   (clk),
        .we    (s_we),
        .waddr (s_waddr),
        .wdata (s_wdata),
        .raddr (s_raddr),
        .rdata (s_rdata)
    );

    // In the second MIX cycle a_reg already holds the freshly written S value.
    always_comb begin
        ab_sum  = a_reg + b_reg;
        a_next  = rotl(s_rdata + ab_sum, RW'(3));
        b_next  = rotl(l_rdata + ab_sum, ab_sum[RW-1:0]);
        s_raddr = i;
        s_waddr = i;
        s_wdata = a_next;
        s_we    = 1'b0;
        l_raddr = j;
        l_waddr = j;
        l_wdata = b_next;
        l_we    = 1'b0;
        case (state)
            LOAD: begin
                l_waddr = i[KAW-1:UAW];
                l_wdata = {key_rdata, lacc};
                l_we    = &i[UAW-1:0];
            end
            INIT: begin
                s_raddr = i - 1'b1;
                s_wdata = (i == '0) ? PW : s_rdata + QW;
                s_we    = 1'b1;
            end
            MIX: begin
                s_we = ~mix_ph;
                l_we = mix_ph;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOAD;
            done   <= 1'b0;
            i      <= '0;
            j      <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            iter   <= '0;
            mix_ph <= 1'b0;
            lacc   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    // Little-endian assembly: older bytes drift toward the low end.
                    lacc <= {key_rdata, lacc[W-9:8]};
                    if (i == I_LAST_KEY) begin
                        i     <= '0;
                        state <= INIT;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                INIT: begin
                    if (i == I_LAST_S) begin
                        i      <= '0;
                        j      <= '0;
                        a_reg  <= '0;
                        b_reg  <= '0;
                        iter   <= '0;
                        mix_ph <= 1'b0;
                        state  <= MIX;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                MIX: begin
                    if (!mix_ph) begin
                        a_reg  <= a_next;
                        mix_ph <= 1'b1;
                    end else begin
                        b_reg  <= b_next;
                        mix_ph <= 1'b0;
                        i      <= (i == I_LAST_S) ? '0 : i + 1'b1;
                        j      <= (j == J_LAST) ? '0 : j + 1'b1;
                        if (iter == IT_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            iter <= iter + 1'b1;
                        end
                    end
                end
                DONE: ;
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: directed and random keys against a plain RC5 key-schedule model.
module tb_key_expander;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    key_expander_if kif();

    key_expander dut (
        .clk  (clk),
        .rst  (rst),
        .done (kif.done)
    );

    int checks   = 0;
    int failures = 0;
    int elapsed  = 0;

    logic [31:0] exp_s [26];
    logic [31:0] exp_l [4];

    localparam logic [127:0] KEY_A = 128'hFFFEEEE58684FFF05FFE493853000434;

    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Textbook RC5 key schedule on plain arrays.
    task automatic build_model(input logic [127:0] key);
        logic [31:0] a;
        logic [31:0] b;
        int ii;
        int jj;
        for (int q = 0; q < 4; q++) exp_l[q] = key[32*q +: 32];
        exp_s[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) exp_s[k] = exp_s[k-1] + 32'h9E3779B9;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int n = 0; n < 78; n++) begin
            a = ref_rotl(exp_s[ii] + a + b, 3);
            exp_s[ii] = a;
            b = ref_rotl(exp_l[jj] + a + b, int'(5'((a + b) & 32'h1F)));
            exp_l[jj] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            elapsed++;
        end
    endtask

    task automatic start(input logic [127:0] key, input bit garbage, input logic [31:0] gval);
        rst = 1'b1;
        #1;
        chk("done_in_reset", {31'b0, kif.done}, 32'd0);
        for (int k = 0; k < 16; k++) dut.key_RAM.ram[k] = key[8*k +: 8];
        if (garbage) begin
            for (int k = 0; k < 26; k++) dut.S_RAM.ram[k] = gval;
            for (int k = 0; k < 4; k++) dut.L_RAM.ram[k] = gval;
        end
        build_model(key);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        elapsed = 0;
    endtask

    task automatic wait_done(input string tag);
        while (kif.done !== 1'b1 && elapsed < 400) step(1);
        chk({tag, "_latency"}, 32'(elapsed), 32'd198);
    endtask

    task automatic check_tables(input string tag);
        for (int k = 0; k < 26; k++)
            chk($sformatf("%s_S%0d", tag, k), dut.S_RAM.ram[k], exp_s[k]);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_L%0d", tag, k), dut.L_RAM.ram[k], exp_l[k]);
    endtask

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] s25;
        logic [127:0] rkey;

        // Given key: phase boundaries, latency, final tables, hold.
        start(KEY_A, 1'b0, 32'h0);
        step(16);
        chk("load_done_low", {31'b0, kif.done}, 32'd0);
        chk("load_L0", dut.L_RAM.ram[0], 32'h53000434);
        chk("load_L1", dut.L_RAM.ram[1], 32'h5FFE4938);
        chk("load_L2", dut.L_RAM.ram[2], 32'h8684FFF0);
        chk("load_L3", dut.L_RAM.ram[3], 32'hFFFEEEE5);
        step(26);
        s25 = 32'hB7E15163 + 32'd25 * 32'h9E3779B9;
        chk("init_S0", dut.S_RAM.ram[0], 32'hB7E15163);
        chk("init_S1", dut.S_RAM.ram[1], 32'h5618CB1C);
        chk("init_S2", dut.S_RAM.ram[2], 32'hF45044D5);
        chk("init_S25", dut.S_RAM.ram[25], s25);
        wait_done("given");
        check_tables("given");
        step(800);
        chk("hold_done", {31'b0, kif.done}, 32'd1);
        check_tables("given_hold");

        // Reset in the middle of MIX, then a full rerun.
        start(KEY_A, 1'b0, 32'h0);
        step(100);
        rst = 1'b1;
        #1;
        chk("midmix_done_low", {31'b0, kif.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        elapsed = 0;
        wait_done("rerun");
        check_tables("rerun");

        // Stale memory contents must not leak into the result.
        start(KEY_A, 1'b1, 32'hDEADBEEF);
        wait_done("garbage");
        check_tables("garbage");

        // All-zero key: first MIX writes and the published RC5 test vector.
        start(128'h0, 1'b1, 32'h12345678);
        step(43);
        chk("zero_first_S0", dut.S_RAM.ram[0], 32'hBF0A8B1D);
        step(1);
        chk("zero_first_L0", dut.L_RAM.ram[0], 32'hB7E15163);
        wait_done("zero");
        check_tables("zero");
        ea = dut.S_RAM.ram[0];
        eb = dut.S_RAM.ram[1];
        for (int r = 1; r <= 12; r++) begin
            ea = ref_rotl(ea ^ eb, int'(eb[4:0])) + dut.S_RAM.ram[2*r];
            eb = ref_rotl(eb ^ ea, int'(ea[4:0])) + dut.S_RAM.ram[2*r+1];
        end
        chk("zero_ct_a", {ea[7:0], ea[15:8], ea[23:16], ea[31:24]}, 32'h21A5DBEE);
        chk("zero_ct_b", {eb[7:0], eb[15:8], eb[23:16], eb[31:24]}, 32'h154B8F6D);

        // Random keys over random stale contents.
        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            start(rkey, 1'b1, $urandom);
            wait_done($sformatf("rand%0d", n));
            check_tables($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
